// File: rtl/recog_frame_sequencer_if.sv
// Bundle of the recognition-cycle control, grid report, result handshake and status signals.
// The master side is the environment that feeds the sequencer; slave is the sequencer itself.
interface recog_frame_sequencer_if #(
    parameter int NUM_WIDTH = 15
);
    logic                 enable;
    logic                 frame_start;
    logic                 proj_done;
    logic [3:0]           num_row;
    logic [3:0]           num_col;
    logic [NUM_WIDTH:0]   digit_in;
    logic                 proj_start;
    logic [1:0]           frame_cnt;
    logic                 project_done_flag;
    logic [7:0]           digit_total;
    logic [NUM_WIDTH:0]   result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 err;
    logic [1:0]           err_code;
    logic [7:0]           ok_count;

    modport master (
        output enable, frame_start, proj_done, num_row, num_col, digit_in, result_ready,
        input  proj_start, frame_cnt, project_done_flag, digit_total, result, result_valid,
               err, err_code, ok_count
    );

    modport slave (
        input  enable, frame_start, proj_done, num_row, num_col, digit_in, result_ready,
        output proj_start, frame_cnt, project_done_flag, digit_total, result, result_valid,
               err, err_code, ok_count
    );
endinterface

// File: rtl/recog_frame_sequencer.sv
// Three-frame recognition sequencer: projection, border arm, feature extraction, then
// holds the captured digits for the consumer until a valid/ready transfer.
module recog_frame_sequencer #(
    parameter int NUM_ROW        = 1,
    parameter int NUM_COL        = 4,
    parameter int NUM_WIDTH      = (NUM_ROW*NUM_COL*4)-1,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    recog_frame_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PROJ, ARM, FEAT, OUT} state_e;

    state_e             state_q, state_d;
    logic [2:0]         tmo_q, tmo_d, tmo_inc;
    logic               proj_start_q, proj_start_d;
    logic [1:0]         frame_cnt_q, frame_cnt_d;
    logic               pdf_q, pdf_d;
    logic [7:0]         digit_total_q, digit_total_d;
    logic [NUM_WIDTH:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [7:0]         ok_count_q, ok_count_d;
    logic               cnt_ok;

    assign cnt_ok = (bus.num_row != 4'd0) && (32'(bus.num_row) <= NUM_ROW) &&
                    (bus.num_col != 4'd0) && (32'(bus.num_col) <= NUM_COL);
    assign tmo_inc = (tmo_q == 3'd7) ? tmo_q : tmo_q + 3'd1;

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        proj_start_d   = 1'b0;
        err_d          = 1'b0;
        err_code_d     = err_code_q;
        digit_total_d  = digit_total_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        ok_count_d     = ok_count_q;
        case (state_q)
            IDLE: begin
                tmo_d = 3'd0;
                if (bus.frame_start && bus.enable) begin
                    state_d      = PROJ;
                    proj_start_d = 1'b1;
                end
            end
            PROJ: begin
                // proj_done outranks a coincident frame_start, which is then not counted
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.proj_done) begin
                    digit_total_d = {4'd0, bus.num_row} * {4'd0, bus.num_col};
                    if (cnt_ok) begin
                        state_d = ARM;
                    end else begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end else if (bus.frame_start) begin
                    tmo_d = tmo_inc;
                    if (32'(tmo_inc) >= TIMEOUT_FRAMES) begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            ARM: begin
                if (!bus.enable)          state_d = IDLE;
                else if (bus.frame_start) state_d = FEAT;
            end
            FEAT: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    state_d        = OUT;
                    result_d       = bus.digit_in;
                    result_valid_d = 1'b1;
                    ok_count_d     = ok_count_q + 8'd1;
                end
            end
            OUT: begin
                if (result_valid_q && bus.result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Phase outputs are registered from the next state so they line up with it
        frame_cnt_d = 2'd0;
        pdf_d       = 1'b0;
        case (state_d)
            ARM:     begin frame_cnt_d = 2'd1; pdf_d = 1'b1; end
            FEAT:    begin frame_cnt_d = 2'd2; pdf_d = 1'b1; end
            OUT:     frame_cnt_d = 2'd3;
            default: frame_cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tmo_q          <= 3'd0;
            proj_start_q   <= 1'b0;
            frame_cnt_q    <= 2'd0;
            pdf_q          <= 1'b0;
            digit_total_q  <= 8'd0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= 2'd0;
            ok_count_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            proj_start_q   <= proj_start_d;
            frame_cnt_q    <= frame_cnt_d;
            pdf_q          <= pdf_d;
            digit_total_q  <= digit_total_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            ok_count_q     <= ok_count_d;
        end
    end

    assign bus.proj_start        = proj_start_q;
    assign bus.frame_cnt         = frame_cnt_q;
    assign bus.project_done_flag = pdf_q;
    assign bus.digit_total       = digit_total_q;
    assign bus.result            = result_q;
    assign bus.result_valid      = result_valid_q;
    assign bus.err               = err_q;
    assign bus.err_code          = err_code_q;
    assign bus.ok_count          = ok_count_q;
endmodule
